// File: rtl/fnanunbox_pipe.sv
// fnanunbox_pipe - NaN-box checker for FP register operands.
//
// Takes raw FLEN-wide operands from the FP register file read port and
// checks that the upper bits above the requested format are all ones.
// Operands that are not properly boxed are replaced by the format's
// canonical NaN, which is itself boxed. The checked value, the format sign
// bit and a bad-box flag go through a one-stage valid/ready pipeline with a
// skid entry. A saturating counter tracks accepted bad-boxed operands.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   InValid / InReady   upstream handshake (InReady is registered)
//   X, Fmt              raw operand and its format code
//   OutValid / OutReady downstream handshake
//   XChk, XSgn, BadBox  checked value, sign of selected format, box failure
//   CntClr, BadBoxCnt   counter clear and saturating bad-box count

package fnanunbox_pkg;
  // Subset of the core configuration record used by this block.
  typedef struct packed {
    int FLEN;
    int FMTBITS;
    int FPSIZES;
    int LEN1;
    int LEN2;
    int FMT1;
    int FMT2;
    int Q_LEN;
    int D_LEN;
    int S_LEN;
    int H_LEN;
    int Q_FMT;
    int D_FMT;
    int S_FMT;
    int H_FMT;
  } cvw_t;

  // RV64 with F and D: FLEN=64, two sizes (D and S).
  localparam cvw_t CVW_RV64FD = '{
    FLEN: 64, FMTBITS: 1, FPSIZES: 2, LEN1: 32, LEN2: 16,
    FMT1: 0, FMT2: 2,
    Q_LEN: 128, D_LEN: 64, S_LEN: 32, H_LEN: 16,
    Q_FMT: 3, D_FMT: 1, S_FMT: 0, H_FMT: 2
  };
endpackage

module fnanunbox_pipe
  import fnanunbox_pkg::*;
#(
  parameter cvw_t P    = CVW_RV64FD,
  parameter int   CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [P.FLEN-1:0]    X,
  input  logic [P.FMTBITS-1:0] Fmt,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [P.FLEN-1:0]    XChk,
  output logic                 XSgn,
  output logic                 BadBox,
  input  logic                 CntClr,
  output logic [CNTW-1:0]      BadBoxCnt
);

  localparam int FLEN = P.FLEN;
  localparam int FB   = P.FMTBITS;
  localparam logic [FLEN-1:0] ONES = '1;
  localparam logic [FLEN-1:0] ONE  = FLEN'(1);

  // ---------------- input-side box check ----------------
  int              w_len;    // width of the selected format
  int              w_ne;     // exponent width of the selected format
  logic [FLEN-1:0] w_upper;  // ones at and above bit w_len
  logic [FLEN-1:0] w_nan;
  logic [FLEN-1:0] w_chk;
  logic            w_good;
  logic            w_sgn;
  logic            w_acc;
  logic            w_drn;

  always_comb begin
    // Unknown encodings fall back to the FLEN format, which is always boxed.
    w_len = FLEN;
    if (P.FPSIZES == 2) begin
      if (Fmt == '0) w_len = P.LEN1;
    end else if (P.FPSIZES == 3) begin
      if      (Fmt == FB'(P.FMT1)) w_len = P.LEN1;
      else if (Fmt == FB'(P.FMT2)) w_len = P.LEN2;
    end else if (P.FPSIZES == 4) begin
      if      (Fmt == FB'(P.Q_FMT)) w_len = P.Q_LEN;
      else if (Fmt == FB'(P.D_FMT)) w_len = P.D_LEN;
      else if (Fmt == FB'(P.S_FMT)) w_len = P.S_LEN;
      else if (Fmt == FB'(P.H_FMT)) w_len = P.H_LEN;
    end

    if      (w_len == 16) w_ne = 5;
    else if (w_len == 32) w_ne = 8;
    else if (w_len == 64) w_ne = 11;
    else                  w_ne = 15;

    // Shifting by w_len == FLEN leaves no upper bits, so the check passes.
    w_upper = ONES << w_len;
    w_good  = ((X & w_upper) == w_upper);

    // Canonical NaN: exponent ones plus fraction MSB, i.e. ne+1 ones
    // directly below the (zero) sign bit, boxed with upper ones.
    w_nan = w_upper | ((~(ONES << (w_ne + 1))) << (w_len - w_ne - 2));
    w_chk = w_good ? X : w_nan;
    w_sgn = |(w_chk & (ONE << (w_len - 1)));
  end

  // ---------------- pipeline with skid ----------------
  logic            r_out_vld;
  logic [FLEN-1:0] r_out_chk;
  logic            r_out_sgn;
  logic            r_out_bad;
  logic            r_skd_vld;
  logic [FLEN-1:0] r_skd_chk;
  logic            r_skd_sgn;
  logic            r_skd_bad;
  logic [CNTW-1:0] r_cnt;

  assign InReady = ~r_skd_vld;
  assign w_acc   = InValid & ~r_skd_vld;
  assign w_drn   = r_out_vld & OutReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_vld <= 1'b0;
      r_out_chk <= '0;
      r_out_sgn <= 1'b0;
      r_out_bad <= 1'b0;
      r_skd_vld <= 1'b0;
      r_skd_chk <= '0;
      r_skd_sgn <= 1'b0;
      r_skd_bad <= 1'b0;
    end else if (w_drn) begin
      if (r_skd_vld) begin
        // Skid refills the output; no accept possible while skid is full.
        r_out_chk <= r_skd_chk;
        r_out_sgn <= r_skd_sgn;
        r_out_bad <= r_skd_bad;
        r_skd_vld <= 1'b0;
      end else if (w_acc) begin
        r_out_chk <= w_chk;
        r_out_sgn <= w_sgn;
        r_out_bad <= ~w_good;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (w_acc) begin
      if (r_out_vld) begin
        r_skd_vld <= 1'b1;
        r_skd_chk <= w_chk;
        r_skd_sgn <= w_sgn;
        r_skd_bad <= ~w_good;
      end else begin
        r_out_vld <= 1'b1;
        r_out_chk <= w_chk;
        r_out_sgn <= w_sgn;
        r_out_bad <= ~w_good;
      end
    end
  end

  // ---------------- bad-box counter ----------------
  always_ff @(posedge clk) begin
    if (reset || CntClr)                  r_cnt <= '0;
    else if (w_acc && !w_good && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign OutValid  = r_out_vld;
  assign XChk      = r_out_chk;
  assign XSgn      = r_out_sgn;
  assign BadBox    = r_out_bad;
  assign BadBoxCnt = r_cnt;

endmodule

// File: tb/tb_fnanunbox_pipe.sv
module tb_fnanunbox_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [63:0] X;
  logic [0:0]  Fmt;
  logic        OutValid;
  logic        OutReady;
  logic [63:0] XChk;
  logic        XSgn;
  logic        BadBox;
  logic        CntClr;
  logic [15:0] BadBoxCnt;

  int total = 0;
  int bad   = 0;

  fnanunbox_pipe dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .X(X), .Fmt(Fmt), .OutValid(OutValid), .OutReady(OutReady),
    .XChk(XChk), .XSgn(XSgn), .BadBox(BadBox), .CntClr(CntClr),
    .BadBoxCnt(BadBoxCnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; InValid = 1'b0; X = '0; Fmt = '0; OutReady = 1'b0; CntClr = 1'b0;
    tick; tick;
    reset = 1'b0;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%0b want=0", OutValid); end
    total++; if (XChk !== 64'h0) begin bad++; $display("FAIL reset_xchk got=%h want=0", XChk); end
    total++; if (XSgn !== 1'b0 || BadBox !== 1'b0) begin bad++; $display("FAIL reset_flags got=%0b%0b want=00", XSgn, BadBox); end
    total++; if (BadBoxCnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", BadBoxCnt); end
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL reset_inready got=%0b want=1", InReady); end
  endtask

  task automatic test_good_single;
    OutReady = 1'b1; Fmt = 1'b0; X = 64'hFFFFFFFF_3F800000; InValid = 1'b1;
    tick;
    InValid = 1'b0;
    total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL good_outvalid got=%0b want=1", OutValid); end
    total++; if (XChk !== 64'hFFFFFFFF_3F800000) begin bad++; $display("FAIL good_xchk got=%h want=ffffffff3f800000", XChk); end
    total++; if (XSgn !== 1'b0 || BadBox !== 1'b0) begin bad++; $display("FAIL good_flags got=%0b%0b want=00", XSgn, BadBox); end
    total++; if (BadBoxCnt !== 16'h0) begin bad++; $display("FAIL good_cnt got=%h want=0", BadBoxCnt); end
    tick;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL good_drained got=%0b want=0", OutValid); end
  endtask

  task automatic test_bad_box;
    OutReady = 1'b1;
    Fmt = 1'b0; X = 64'h00000000_BF800000; InValid = 1'b1;
    tick;
    total++; if (XChk !== 64'hFFFFFFFF_7FC00000) begin bad++; $display("FAIL bad_s_xchk got=%h want=ffffffff7fc00000", XChk); end
    total++; if (XSgn !== 1'b0 || BadBox !== 1'b1) begin bad++; $display("FAIL bad_s_flags got=%0b%0b want=01", XSgn, BadBox); end
    total++; if (BadBoxCnt !== 16'h1) begin bad++; $display("FAIL bad_s_cnt got=%h want=1", BadBoxCnt); end
    Fmt = 1'b1; X = 64'h00000000_BF800000;
    tick;
    total++; if (XChk !== 64'h00000000_BF800000) begin bad++; $display("FAIL d_pass_xchk got=%h want=00000000bf800000", XChk); end
    total++; if (XSgn !== 1'b0 || BadBox !== 1'b0) begin bad++; $display("FAIL d_pass_flags got=%0b%0b want=00", XSgn, BadBox); end
    total++; if (BadBoxCnt !== 16'h1) begin bad++; $display("FAIL d_pass_cnt got=%h want=1", BadBoxCnt); end
    Fmt = 1'b1; X = 64'hBFF00000_00000000;
    tick;
    total++; if (XSgn !== 1'b1 || XChk !== 64'hBFF00000_00000000) begin bad++; $display("FAIL d_neg got=%0b/%h want=1/bff0000000000000", XSgn, XChk); end
    Fmt = 1'b0; X = 64'hFFFFFFFF_BF800000;
    tick;
    InValid = 1'b0;
    total++; if (XSgn !== 1'b1 || BadBox !== 1'b0 || XChk !== 64'hFFFFFFFF_BF800000) begin bad++; $display("FAIL s_neg got=%0b%0b/%h want=10/ffffffffbf800000", XSgn, BadBox, XChk); end
    tick;
  endtask

  task automatic test_backpressure;
    Fmt = 1'b1; OutReady = 1'b0;
    X = 64'hAAAA0000_0000000A; InValid = 1'b1;
    tick;
    X = 64'hBBBB0000_0000000B;
    tick;
    X = 64'hCCCC0000_0000000C;
    total++; if (InReady !== 1'b0) begin bad++; $display("FAIL bp_full_inready got=%0b want=0", InReady); end
    total++; if (OutValid !== 1'b1 || XChk !== 64'hAAAA0000_0000000A) begin bad++; $display("FAIL bp_head got=%0b/%h want=1/aaaa00000000000a", OutValid, XChk); end
    tick; tick;
    total++; if (InReady !== 1'b0 || XChk !== 64'hAAAA0000_0000000A) begin bad++; $display("FAIL bp_hold got=%0b/%h want=0/aaaa00000000000a", InReady, XChk); end
    OutReady = 1'b1;
    tick;
    total++; if (OutValid !== 1'b1 || XChk !== 64'hBBBB0000_0000000B) begin bad++; $display("FAIL bp_second got=%0b/%h want=1/bbbb00000000000b", OutValid, XChk); end
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%0b want=1", InReady); end
    tick;
    InValid = 1'b0;
    total++; if (OutValid !== 1'b1 || XChk !== 64'hCCCC0000_0000000C) begin bad++; $display("FAIL bp_third got=%0b/%h want=1/cccc00000000000c", OutValid, XChk); end
    tick;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b want=0", OutValid); end
  endtask

  task automatic test_streaming;
    Fmt = 1'b1; OutReady = 1'b1; InValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      X = 64'h100 + 64'(i);
      tick;
      total++;
      if (OutValid !== 1'b1 || InReady !== 1'b1 || XChk !== 64'h100 + 64'(i)) begin
        bad++;
        $display("FAIL stream_%0d got=%0b%0b/%h want=11/%h", i, OutValid, InReady, XChk, 64'h100 + 64'(i));
      end
    end
    InValid = 1'b0;
    tick;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL stream_end got=%0b want=0", OutValid); end
  endtask

  task automatic test_counter;
    OutReady = 1'b1; CntClr = 1'b1;
    tick;
    CntClr = 1'b0;
    total++; if (BadBoxCnt !== 16'h0) begin bad++; $display("FAIL cnt_clear got=%h want=0", BadBoxCnt); end
    Fmt = 1'b0; X = 64'h0; InValid = 1'b1;
    repeat (65534) tick;
    total++; if (BadBoxCnt !== 16'hFFFE) begin bad++; $display("FAIL cnt_preload got=%h want=fffe", BadBoxCnt); end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (BadBoxCnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat_%0d got=%h want=ffff", i, BadBoxCnt); end
    end
    CntClr = 1'b1;
    tick;
    CntClr = 1'b0;
    total++; if (BadBoxCnt !== 16'h0) begin bad++; $display("FAIL cnt_clr_prio got=%h want=0", BadBoxCnt); end
    tick;
    InValid = 1'b0;
    total++; if (BadBoxCnt !== 16'h1) begin bad++; $display("FAIL cnt_after_clr got=%h want=1", BadBoxCnt); end
    tick;
  endtask

  task automatic test_reset_mid;
    OutReady = 1'b0; Fmt = 1'b0; X = 64'h12345678_00000000; InValid = 1'b1;
    tick; tick;
    InValid = 1'b0;
    total++; if (InReady !== 1'b0 || OutValid !== 1'b1) begin bad++; $display("FAIL rst_mid_full got=%0b%0b want=01", InReady, OutValid); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin bad++; $display("FAIL rst_mid_state got=%0b%0b want=01", OutValid, InReady); end
    total++; if (BadBoxCnt !== 16'h0 || XChk !== 64'h0) begin bad++; $display("FAIL rst_mid_regs got=%h/%h want=0/0", BadBoxCnt, XChk); end
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale_%0d got=%0b want=0", i, OutValid); end
    end
  endtask

  initial begin
    test_reset;
    test_good_single;
    test_bad_box;
    test_backpressure;
    test_streaming;
    test_counter;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnanunbox_pipe.md
Name: fnanunbox_pipe

Overview:
Read-side counterpart of the FPU's NaN-boxing result formatter. It accepts raw FLEN-wide FP register operands and checks NaN-boxing for the requested format. Improperly boxed operands are replaced by that format's canonical NaN, still boxed. It emits the checked value, the format sign bit and a bad-box flag through a one-stage valid/ready pipeline with a skid buffer. It sits between the FP register file read port and the FPU operand unpack logic, and keeps a saturating count of boxing violations for performance/debug.

Parameters:
P, cvw_t, core configuration record; this block uses FLEN, FMTBITS, FPSIZES, LEN1, LEN2, and Q/D/S/H_LEN and Q/D/S/H_FMT when FPSIZES=4.
CNTW, 16, width of the bad-box counter.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
InValid  input  1  upstream operand valid
InReady  output  1  block can accept an operand this cycle
X  input  P.FLEN  raw register value
Fmt  input  P.FMTBITS  operand format; encoding matches FPU Fmt (FPSIZES=2: 1=FLEN format, 0=LEN1 format)
OutValid  output  1  output entry valid
OutReady  input  1  downstream accepts output
XChk  output  P.FLEN  checked value, boxed, canonical NaN substituted when bad
XSgn  output  1  sign bit of the selected format taken from XChk
BadBox  output  1  the operand failed the NaN-box check
CntClr  input  1  synchronous clear of BadBoxCnt
BadBoxCnt  output  CNTW  saturating count of accepted bad-boxed operands

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values: OutValid=0, XChk=0, XSgn=0, BadBox=0, BadBoxCnt=0, skid entry invalid. InReady=1 in the first cycle after reset.
- Box check (combinational, on input side):
  - Format of width L < FLEN is boxed iff X[FLEN-1:L] is all ones.
  - Format L = FLEN is always boxed.
  - FPSIZES=1: check is always true.
  - Fmt encodings not defined for the config: treat as FLEN format (no check).
- Canonical NaN for width L: sign 0, exponent all ones, fraction MSB 1, rest 0, with upper FLEN-L bits set to 1.
  - Example: S = 0xFFFFFFFF_7FC00000, D = 0x7FF80000_00000000, H within FLEN=64 = 0xFFFFFFFF_FFFF7E00.
- XChk = good ? X : canonical NaN. XSgn = XChk[L-1]. BadBox = ~good.
- Pipeline:
  - Main output register plus one skid entry. Latency is 1 cycle: an operand accepted at edge n is presented with OutValid=1 after edge n.
  - Accept occurs when InValid & InReady. Drain occurs when OutValid & OutReady.
  - InReady = ~SkidValid (registered, no combinational path from OutReady).
- Skid rules:
  - Accept while output is valid and not draining: the entry goes to the skid and SkidValid is set.
  - Drain while SkidValid: the skid moves to the output and SkidValid is cleared.
  - Accept and drain in the same cycle with skid empty: the new entry goes directly to the output.
  - Order is strictly preserved. No entry is dropped or duplicated. Maximum occupancy is 2.
- OutValid and the output data hold stable while OutValid & ~OutReady.
- Counter:
  - Increments by 1 on each accept with BadBox=1.
  - Saturates at 2^CNTW-1.
  - CntClr has priority: the counter is 0 the next cycle even if an increment coincides.
- reset asserted mid-operation discards both entries and returns all state to reset values.

Test Plan:
1. FLEN=64, FPSIZES=2: Fmt=0, X=0xFFFFFFFF_3F800000, OutReady=1 -> one cycle later OutValid=1, XChk=0xFFFFFFFF_3F800000, XSgn=0, BadBox=0, BadBoxCnt=0.
2. Fmt=0, X=0x00000000_BF800000 -> XChk=0xFFFFFFFF_7FC00000, XSgn=0, BadBox=1, BadBoxCnt=1. Fmt=1, X=0x00000000_BF800000 -> passes unchanged, BadBox=0, XSgn=0.
3. Backpressure: OutReady=0, send A then B -> InReady=0 after B, C held off. Raise OutReady -> A, B, C emerge in order with no loss or duplication.
4. Streaming: InValid=1 and OutReady=1 every cycle for 20 operands -> one output per cycle, InReady stays 1.
5. Counter: preload to 0xFFFE, send 3 bad operands -> 0xFFFF held. CntClr coincident with a bad accept -> 0.
6. reset pulsed with 2 entries buffered -> next cycle OutValid=0, InReady=1, BadBoxCnt=0, and no stale entry appears afterward.
